// File: rtl/calc_pkg.sv
// Shared definitions for the keypad calculator core: operator codes,
// state encoding and the saturating range check.
package calc_pkg;

  localparam int MAX_W = 16;
  localparam int WIDE  = 2 * MAX_W + 2;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MUL = 2'b10,
    OP_EQ  = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    S_A    = 3'd0,
    S_B    = 3'd1,
    S_EXEC = 3'd2,
    S_MUL  = 3'd3,
    S_RES  = 3'd4
  } state_e;

  // Clamp a wide signed value into a 'width'-bit two's-complement range.
  // Bit MAX_W of the return flags saturation; the low 'width' bits hold the value.
  function automatic logic [MAX_W:0] saturate(input logic signed [WIDE-1:0] val,
                                               input int width);
    logic signed [WIDE-1:0] max_v;
    logic signed [WIDE-1:0] min_v;
    logic [MAX_W:0]         res;
    max_v = $signed((34'd1 << (width - 1)) - 34'd1);
    min_v = -max_v - 34'sd1;
    if (val > max_v) begin
      res = {1'b1, max_v[MAX_W-1:0]};
    end else if (val < min_v) begin
      res = {1'b1, min_v[MAX_W-1:0]};
    end else begin
      res = {1'b0, val[MAX_W-1:0]};
    end
    return res;
  endfunction

endpackage

// File: rtl/calc_mul_seq.sv
// Sequential unsigned shift-add multiplier: one multiplier bit per cycle,
// WIDTH cycles after start, then a one-cycle done pulse. Abort is synchronous.
module calc_mul_seq #(
  parameter int WIDTH = 8
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               abort_i,
  input  logic               start_i,
  input  logic [WIDTH-1:0]   mcand_i,
  input  logic [WIDTH-1:0]   mplier_i,
  output logic [2*WIDTH-1:0] product_o,
  output logic               done_o
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [2*WIDTH-1:0] mcand_q;
  logic [2*WIDTH-1:0] prod_q;
  logic [WIDTH-1:0]   mplier_q;
  logic [CW-1:0]      cnt_q;
  logic               busy_q;
  logic               done_q;

  // Load operands on start, then accumulate and shift once per cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mcand_q  <= {(2*WIDTH){1'b0}};
      prod_q   <= {(2*WIDTH){1'b0}};
      mplier_q <= {WIDTH{1'b0}};
      cnt_q    <= {CW{1'b0}};
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else if (abort_i) begin
      mcand_q  <= {(2*WIDTH){1'b0}};
      prod_q   <= {(2*WIDTH){1'b0}};
      mplier_q <= {WIDTH{1'b0}};
      cnt_q    <= {CW{1'b0}};
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else if (start_i) begin
      mcand_q  <= {{WIDTH{1'b0}}, mcand_i};
      prod_q   <= {(2*WIDTH){1'b0}};
      mplier_q <= mplier_i;
      cnt_q    <= CW'(WIDTH);
      busy_q   <= 1'b1;
      done_q   <= 1'b0;
    end else if (busy_q) begin
      prod_q   <= mplier_q[0] ? (prod_q + mcand_q) : prod_q;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q - CW'(1);
      if (cnt_q == CW'(1)) begin
        busy_q <= 1'b0;
        done_q <= 1'b1;
      end else begin
        busy_q <= 1'b1;
        done_q <= 1'b0;
      end
    end else begin
      done_q <= 1'b0;
    end
  end

  assign product_o = prod_q;
  assign done_o    = done_q;

endmodule

// File: rtl/calc_core.sv
// Calculator control and arithmetic: chained operators, repeat-equals,
// saturating add/sub and a sequential multiply with sticky overflow.
module calc_core
  import calc_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter bit ENABLE_MUL = 1'b1
) (
  input  logic             i_CLOCK,
  input  logic             i_RESET_N,
  input  logic             i_CLEAR_ALL,
  input  logic             i_CLEAR_ENTRY,
  input  logic             i_LOAD,
  input  logic [WIDTH-1:0] i_OPERAND,
  input  logic             i_KEY,
  input  logic [1:0]       i_OP,
  output logic [WIDTH-1:0] o_DISPLAY,
  output logic             o_DISP_SEL,
  output logic             o_OVF,
  output logic             o_BUSY,
  output logic [1:0]       o_PEND_OP,
  output logic [2:0]       o_STATE
);

  state_e           state_q, state_d;
  op_e              pend_q, pend_d, nop_q, nop_d;
  logic [WIDTH-1:0] entry_q, entry_d, a_q, a_d, b_q, b_d, r_q, r_d;
  logic             nxt_res_q, nxt_res_d, ovf_q, ovf_d;
  logic [WIDTH-1:0] disp_q, disp_d;
  logic             disp_sel_q, disp_sel_d, busy_q, busy_d;

  op_e                    op_s;
  logic                   key_ok_s;
  logic signed [WIDE-1:0] a_ext_s, b_ext_s, sum_s, prod_ext_s, prod_sgn_s;
  logic [MAX_W:0]         sat_add_s, sat_mul_s;
  logic [WIDTH:0]         a_neg_s, m_neg_s;
  logic [WIDTH-1:0]       a_mag_s, m_src_s, m_mag_s;
  logic                   mul_start_s, mul_done_s;
  logic [2*WIDTH-1:0]     mul_prod_s;
  logic                   unused_s;

  assign op_s     = op_e'(i_OP);
  assign key_ok_s = i_KEY && !((op_s == OP_MUL) && !ENABLE_MUL);

  // Saturating add/sub on sign-extended operands.
  assign a_ext_s   = {{(WIDE-WIDTH){a_q[WIDTH-1]}}, a_q};
  assign b_ext_s   = {{(WIDE-WIDTH){b_q[WIDTH-1]}}, b_q};
  assign sum_s     = (pend_q == OP_SUB) ? (a_ext_s - b_ext_s) : (a_ext_s + b_ext_s);
  assign sat_add_s = saturate(sum_s, WIDTH);

  // Magnitudes use a WIDTH+1 negation so the most negative value does not wrap.
  assign m_src_s = (state_q == S_B) ? entry_q : b_q;
  assign a_neg_s = -{a_q[WIDTH-1], a_q};
  assign m_neg_s = -{m_src_s[WIDTH-1], m_src_s};
  assign a_mag_s = a_q[WIDTH-1] ? a_neg_s[WIDTH-1:0] : a_q;
  assign m_mag_s = m_src_s[WIDTH-1] ? m_neg_s[WIDTH-1:0] : m_src_s;

  // Signed, range-checked product once the unsigned multiply finishes.
  assign prod_ext_s = {{(WIDE-2*WIDTH){1'b0}}, mul_prod_s};
  assign prod_sgn_s = (a_q[WIDTH-1] ^ b_q[WIDTH-1]) ? -prod_ext_s : prod_ext_s;
  assign sat_mul_s  = saturate(prod_sgn_s, WIDTH);

  assign unused_s = ^{sat_add_s, sat_mul_s, a_neg_s[WIDTH], m_neg_s[WIDTH]};

  calc_mul_seq #(.WIDTH(WIDTH)) u_mul (
    .clk_i     (i_CLOCK),
    .rst_ni    (i_RESET_N),
    .abort_i   (i_CLEAR_ALL),
    .start_i   (mul_start_s),
    .mcand_i   (a_mag_s),
    .mplier_i  (m_mag_s),
    .product_o (mul_prod_s),
    .done_o    (mul_done_s)
  );

  // Next-state, datapath register and output decode.
  always_comb begin
    state_d     = state_q;
    entry_d     = entry_q;
    a_d         = a_q;
    b_d         = b_q;
    r_d         = r_q;
    pend_d      = pend_q;
    nop_d       = nop_q;
    nxt_res_d   = nxt_res_q;
    ovf_d       = ovf_q;
    mul_start_s = 1'b0;
    if (i_CLEAR_ALL) begin
      state_d   = S_A;
      entry_d   = {WIDTH{1'b0}};
      a_d       = {WIDTH{1'b0}};
      b_d       = {WIDTH{1'b0}};
      r_d       = {WIDTH{1'b0}};
      pend_d    = OP_ADD;
      nop_d     = OP_ADD;
      nxt_res_d = 1'b0;
      ovf_d     = 1'b0;
    end else begin
      case (state_q)
        S_EXEC: begin
          r_d   = sat_add_s[WIDTH-1:0];
          a_d   = sat_add_s[WIDTH-1:0];
          ovf_d = ovf_q | sat_add_s[MAX_W];
          if (nxt_res_q) begin
            state_d = S_RES;
          end else begin
            state_d = S_B;
            pend_d  = nop_q;
          end
        end
        S_MUL: begin
          if (mul_done_s) begin
            r_d   = sat_mul_s[WIDTH-1:0];
            a_d   = sat_mul_s[WIDTH-1:0];
            ovf_d = ovf_q | sat_mul_s[MAX_W];
            if (nxt_res_q) begin
              state_d = S_RES;
            end else begin
              state_d = S_B;
              pend_d  = nop_q;
            end
          end else begin
            state_d = S_MUL;
          end
        end
        S_A, S_B, S_RES: begin
          if (i_LOAD) begin
            entry_d = i_OPERAND;
            state_d = (state_q == S_RES) ? S_A : state_q;
          end else if (i_CLEAR_ENTRY) begin
            entry_d = {WIDTH{1'b0}};
          end else if (key_ok_s) begin
            case (state_q)
              S_A: begin
                if (op_s == OP_EQ) begin
                  r_d     = entry_q;
                  a_d     = entry_q;
                  b_d     = {WIDTH{1'b0}};
                  pend_d  = OP_ADD;
                  state_d = S_RES;
                end else begin
                  a_d     = entry_q;
                  pend_d  = op_s;
                  state_d = S_B;
                end
              end
              S_B: begin
                b_d       = entry_q;
                nxt_res_d = (op_s == OP_EQ);
                nop_d     = op_s;
                if (pend_q == OP_MUL) begin
                  mul_start_s = 1'b1;
                  state_d     = S_MUL;
                end else begin
                  state_d = S_EXEC;
                end
              end
              S_RES: begin
                if (op_s == OP_EQ) begin
                  nxt_res_d = 1'b1;
                  nop_d     = pend_q;
                  if (pend_q == OP_MUL) begin
                    mul_start_s = 1'b1;
                    state_d     = S_MUL;
                  end else begin
                    state_d = S_EXEC;
                  end
                end else begin
                  pend_d  = op_s;
                  state_d = S_B;
                end
              end
              default: state_d = S_A;
            endcase
          end else begin
            state_d = state_q;
          end
        end
        default: state_d = S_A;
      endcase
    end
    disp_sel_d = (state_d == S_RES) || (state_d == S_EXEC) || (state_d == S_MUL);
    busy_d     = (state_d == S_EXEC) || (state_d == S_MUL);
    disp_d     = disp_sel_d ? r_d : entry_d;
  end

  // State, datapath and output registers.
  always_ff @(posedge i_CLOCK or negedge i_RESET_N) begin
    if (!i_RESET_N) begin
      state_q    <= S_A;
      entry_q    <= {WIDTH{1'b0}};
      a_q        <= {WIDTH{1'b0}};
      b_q        <= {WIDTH{1'b0}};
      r_q        <= {WIDTH{1'b0}};
      pend_q     <= OP_ADD;
      nop_q      <= OP_ADD;
      nxt_res_q  <= 1'b0;
      ovf_q      <= 1'b0;
      disp_q     <= {WIDTH{1'b0}};
      disp_sel_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      entry_q    <= entry_d;
      a_q        <= a_d;
      b_q        <= b_d;
      r_q        <= r_d;
      pend_q     <= pend_d;
      nop_q      <= nop_d;
      nxt_res_q  <= nxt_res_d;
      ovf_q      <= ovf_d;
      disp_q     <= disp_d;
      disp_sel_q <= disp_sel_d;
      busy_q     <= busy_d;
    end
  end

  assign o_DISPLAY  = disp_q;
  assign o_DISP_SEL = disp_sel_q;
  assign o_OVF      = ovf_q;
  assign o_BUSY     = busy_q;
  assign o_PEND_OP  = pend_q;
  assign o_STATE    = state_q;

endmodule

// File: tb/tb_calc_core.sv
// Directed bench for calc_core at WIDTH=8 with hand-computed expectations.
module tb_calc_core;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         clr_all, clr_entry, load, key;
  logic [W-1:0] operand;
  logic [1:0]   op;
  logic [W-1:0] disp;
  logic         disp_sel, ovf, busy;
  logic [1:0]   pend;
  logic [2:0]   state;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc;

  localparam logic [1:0] ADD = 2'b00, SUB = 2'b01, MUL = 2'b10, EQ = 2'b11;

  calc_core #(.WIDTH(W), .ENABLE_MUL(1'b1)) dut (
    .i_CLOCK       (clk),
    .i_RESET_N     (rst_n),
    .i_CLEAR_ALL   (clr_all),
    .i_CLEAR_ENTRY (clr_entry),
    .i_LOAD        (load),
    .i_OPERAND     (operand),
    .i_KEY         (key),
    .i_OP          (op),
    .o_DISPLAY     (disp),
    .o_DISP_SEL    (disp_sel),
    .o_OVF         (ovf),
    .o_BUSY        (busy),
    .o_PEND_OP     (pend),
    .o_STATE       (state)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [W-1:0] v);
    load = 1'b1; operand = v;
    step();
    load = 1'b0;
  endtask

  task automatic do_key(input logic [1:0] o);
    key = 1'b1; op = o;
    step();
    key = 1'b0;
  endtask

  task automatic do_clear();
    clr_all = 1'b1;
    step();
    clr_all = 1'b0;
  endtask

  // Step while busy, bounded; returns the number of busy cycles observed.
  task automatic wait_idle(output int n);
    n = 0;
    while (busy && n < 40) begin
      step();
      n++;
    end
  endtask

  initial begin
    rst_n = 1'b0; clr_all = 1'b0; clr_entry = 1'b0; load = 1'b0; key = 1'b0;
    operand = '0; op = 2'b00;
    #12;
    chk("rst_disp",  16'(disp), 16'h0000);
    chk("rst_state", 16'(state), 16'h0000);
    chk("rst_flags", 16'({disp_sel, ovf, busy, pend}), 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;

    // 5 + 3 = 8, two cycles after the equals key
    do_load(8'd5);
    chk("load_disp", 16'(disp), 16'h0005);
    do_key(ADD);
    chk("after_add_state", 16'(state), 16'h0001);
    do_load(8'd3);
    do_key(EQ);
    chk("exec_state", 16'(state), 16'h0002);
    chk("exec_busy_sel", 16'({busy, disp_sel}), 16'h0003);
    chk("exec_prev_r", 16'(disp), 16'h0000);
    step();
    chk("add_res", 16'(disp), 16'h0008);
    chk("add_state", 16'(state), 16'h0004);
    chk("add_ovf", 16'(ovf), 16'h0000);

    // 100 + 100 saturates to 127, overflow sticks through a clean 1 - 1
    do_load(8'd100); do_key(ADD); do_load(8'd100); do_key(EQ); step();
    chk("sat_res", 16'(disp), 16'h007F);
    chk("sat_ovf", 16'(ovf), 16'h0001);
    do_load(8'd1); do_key(SUB); do_load(8'd1); do_key(EQ); step();
    chk("sub_res", 16'(disp), 16'h0000);
    chk("ovf_sticky", 16'(ovf), 16'h0001);
    do_clear();
    chk("ovf_cleared", 16'(ovf), 16'h0000);

    // -7 * 6 = -42, busy for exactly 9 cycles
    do_load(8'hF9); do_key(MUL);
    chk("mul_pend", 16'(pend), 16'h0002);
    do_load(8'd6); do_key(EQ);
    wait_idle(cyc);
    chk("mul_busy_cycles", 16'(cyc), 16'd9);
    chk("mul_res", 16'(disp), 16'h00D6);
    chk("mul_state", 16'(state), 16'h0004);

    // -128 * 1 = -128 without overflow; a load during busy is dropped
    do_load(8'h80); do_key(MUL); do_load(8'd1); do_key(EQ);
    do_load(8'd55);
    wait_idle(cyc);
    chk("mul_min_res", 16'(disp), 16'h0080);
    chk("mul_min_ovf", 16'(ovf), 16'h0000);
    do_key(ADD);
    chk("entry_kept", 16'(disp), 16'h0001);
    chk("res_op_state", 16'({pend, state}), 16'({ADD, 3'd1}));
    do_clear();

    // Chain 2 + 3 * 4 = 20
    do_load(8'd2); do_key(ADD); do_load(8'd3); do_key(MUL); step();
    chk("chain_state", 16'(state), 16'h0001);
    chk("chain_pend", 16'(pend), 16'h0002);
    do_load(8'd4); do_key(EQ);
    wait_idle(cyc);
    chk("chain_res", 16'(disp), 16'h0014);

    // Repeat-equals: 10 - 3 = 7, then 4, then 1
    do_load(8'd10); do_key(SUB); do_load(8'd3); do_key(EQ); step();
    chk("rep1", 16'(disp), 16'h0007);
    do_key(EQ); step();
    chk("rep2", 16'(disp), 16'h0004);
    do_key(EQ); step();
    chk("rep3", 16'(disp), 16'h0001);
    chk("rep_pend", 16'(pend), 16'h0001);

    // Abort a multiply; keys during busy are ignored
    do_clear();
    do_load(8'd3); do_key(MUL); do_load(8'd5); do_key(EQ);
    key = 1'b1; op = ADD; load = 1'b1; operand = 8'd9;
    step();
    key = 1'b0; load = 1'b0;
    chk("busy_keys_state", 16'(state), 16'h0003);
    chk("busy_keys_pend", 16'(pend), 16'h0002);
    step();
    do_clear();
    chk("abort_state", 16'(state), 16'h0000);
    chk("abort_disp", 16'(disp), 16'h0000);
    chk("abort_busy", 16'(busy), 16'h0000);
    do_load(8'd2); do_key(ADD); do_load(8'd2); do_key(EQ); step();
    chk("post_abort_res", 16'(disp), 16'h0004);

    // Asynchronous reset in the middle of S_B
    do_load(8'd100); do_key(ADD); do_load(8'd100); do_key(EQ); step();
    do_load(8'd4); do_key(SUB);
    chk("pre_rst_state", 16'({ovf, pend, state}), 16'({1'b1, SUB, 3'd1}));
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_disp", 16'(disp), 16'h0000);
    chk("async_state", 16'(state), 16'h0000);
    chk("async_flags", 16'({disp_sel, ovf, busy, pend}), 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;

    // LOAD beats CLEAR_ENTRY and KEY in the same cycle
    clr_entry = 1'b1; key = 1'b1; op = ADD;
    do_load(8'd7);
    clr_entry = 1'b0; key = 1'b0;
    chk("load_prio_disp", 16'(disp), 16'h0007);
    chk("load_prio_state", 16'(state), 16'h0000);
    clr_entry = 1'b1;
    step();
    clr_entry = 1'b0;
    chk("clear_entry", 16'(disp), 16'h0000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/calc_core.md
Name: calc_core

Overview:
- Parametrised control-plus-arithmetic core for the keypad calculator. It replaces the fixed 8-bit A/B add-subtract path and its separate control unit.
- Sits between the keypad input unit, which supplies a signed operand and key strobes, and the seven-segment output unit, which consumes o_DISPLAY.
- Adds four things over the fixed path: chained operations, repeat-equals, a sequential shift-add multiply, and saturating arithmetic with a sticky overflow flag.

Parameters:
- WIDTH, 8, two's-complement operand/result width (4..16).
- ENABLE_MUL, 1, 1 = multiply operator implemented; 0 = multiply keys ignored.

Ports:
- i_CLOCK  in  1  system clock, rising edge.
- i_RESET_N  in  1  asynchronous, active-low reset.
- i_CLEAR_ALL  in  1  synchronous clear, one-cycle strobe.
- i_CLEAR_ENTRY  in  1  synchronous strobe; zeroes the entry register only.
- i_LOAD  in  1  one-cycle strobe; entry register <= i_OPERAND.
- i_OPERAND  in  WIDTH  signed operand from the input unit.
- i_KEY  in  1  one-cycle operator/equals strobe.
- i_OP  in  2  operator code: 00 add, 01 sub, 10 mul, 11 equals.
- o_DISPLAY  out  WIDTH  value to show: result if o_DISP_SEL, else entry.
- o_DISP_SEL  out  1  1 = result shown.
- o_OVF  out  1  sticky overflow/saturation flag.
- o_BUSY  out  1  execution in progress.
- o_PEND_OP  out  2  pending operator, for the HEX5 indicator.
- o_STATE  out  3  state encoding, for the LEDs.

Behaviour:
- Registers: ENTRY, A, B, R (all WIDTH bits); PEND (2 bits); state.
- Reset (async or i_CLEAR_ALL): all registers 0, PEND=00, state S_A, o_OVF=0, o_BUSY=0, o_DISP_SEL=0. i_CLEAR_ALL aborts any multiply in progress.
- State encoding: S_A=0, S_B=1, S_EXEC=2, S_MUL=3, S_RES=4.
- While o_BUSY: i_LOAD, i_KEY and i_CLEAR_ENTRY are dropped, not queued.
- Same-cycle priority: i_CLEAR_ALL > i_LOAD > i_CLEAR_ENTRY > i_KEY. A lower-priority strobe arriving with a higher one is dropped.
- Multiply key with ENABLE_MUL=0: dropped entirely, no state change.
- S_A:
  - operator: A<=ENTRY, PEND<=op, go S_B.
  - equals: R<=ENTRY, B<=0, PEND<=add, go S_RES.
- S_B:
  - operator or equals: B<=ENTRY, go S_EXEC (add/sub) or S_MUL (mul).
  - The triggering key is remembered: equals -> NEXT=S_RES; operator -> NEXT=S_B with PEND<=new op after completion.
- S_EXEC (1 cycle):
  - Compute A±B at WIDTH+1 bits, sign-extended.
  - If the value is out of range: saturate to +2^(W-1)-1 or -2^(W-1), and set o_OVF.
  - R<=result, A<=result, go NEXT.
  - Latency: result visible 2 cycles after the key cycle.
- S_MUL (WIDTH cycles + 1 finalize cycle):
  - Unsigned shift-add on |A| and |B|, one bit per cycle, into a 2*WIDTH-bit product.
  - Finalize: apply sign A[msb]^B[msb], then range-check.
  - Negative results may reach magnitude 2^(W-1); positive results only 2^(W-1)-1. Beyond that: saturate and set o_OVF.
  - Then R, A <= result and go NEXT.
  - Key-to-result latency: WIDTH+2 cycles.
- S_RES:
  - operator: PEND<=op (A already holds R), go S_B. ENTRY is not cleared.
  - equals: repeat — re-execute PEND with A=R and the held B.
  - i_LOAD: ENTRY<=operand, go S_A (new calculation). o_OVF is kept until CLEAR_ALL.
- o_DISP_SEL: 1 in S_RES, S_EXEC and S_MUL; 0 otherwise. During execution the display shows the previous R.
- o_BUSY: 1 exactly in S_EXEC and S_MUL.
- Negating the most negative operand for the multiply magnitude uses a WIDTH+1-bit intermediate; there is no wrap.

Decomposition:
- Package calc_pkg holds:
  - op codes: OP_ADD, OP_SUB, OP_MUL, OP_EQ;
  - state encoding constants;
  - a saturate function (signed value, width).
- One sub-module, calc_mul_seq: a WIDTH-parametrised sequential unsigned shift-add multiplier.
  - Inputs: start, multiplicand, multiplier.
  - Outputs: product, done.
  - Supports synchronous abort.

Test Plan (WIDTH=8):
- LOAD 5, KEY add, LOAD 3, KEY eq -> o_DISPLAY=8 two cycles later; o_STATE=4; o_OVF=0.
- LOAD 100, add, LOAD 100, eq -> o_DISPLAY=127 (0x7F), o_OVF=1. Then LOAD 1, sub, LOAD 1, eq -> 0; o_OVF still 1 until CLEAR_ALL.
- LOAD -7, mul, LOAD 6, eq -> o_BUSY high exactly 9 cycles, then o_DISPLAY=-42 (0xD6). Also LOAD -128, mul, LOAD 1, eq -> -128 with no OVF.
- Chain: 2 add 3 mul (display 5, o_PEND_OP=mul) 4 eq -> 20. Repeat-equals: 10 sub 3 eq -> 7; eq -> 4; eq -> 1.
- Abort: CLEAR_ALL 3 cycles into the multiply -> next cycle o_STATE=0, o_DISPLAY=0, o_BUSY=0. Keys pressed during o_BUSY have no effect.
- Assert i_RESET_N low mid-S_B, asynchronously between clock edges -> all outputs at reset values immediately, no clock needed. Also LOAD and CLEAR_ENTRY in the same cycle -> ENTRY takes the operand.
